// File: rtl/mstq_arbiter.sv
// Packet-granular two-port arbiter merging PHY receiver command streams into the shared master FIFO.
// Optional per-port completed-command counters are built when MSTQ_ARB_STATS_EN is defined.
module mstq_arbiter #(
  parameter int FAIR = 1
) (
  input  logic        clk_125,
  input  logic        sys_rst,
  input  logic [1:0]  port_en,
  input  logic        rx0_mst_empty,
  input  logic [17:0] rx0_mst_dout,
  output logic        rx0_mst_rd_en,
  input  logic        rx1_mst_empty,
  input  logic [17:0] rx1_mst_dout,
  output logic        rx1_mst_rd_en,
  output logic [17:0] mst_din,
  output logic        mst_wr_en,
  input  logic        mst_full,
  output logic [1:0]  grant,
  output logic        proto_err,
  output logic [15:0] pkt0_cnt,
  output logic [15:0] pkt1_cnt
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t state;
  logic   last_served;
  logic   elig0, elig1, bad0, bad1;
  logic   xfer0, xfer1, end0, end1;
  logic   disc0, disc1, pick1;

  assign elig0 = port_en[0] & ~rx0_mst_empty & rx0_mst_dout[17];
  assign elig1 = port_en[1] & ~rx1_mst_empty & rx1_mst_dout[17];
  assign bad0  = port_en[0] & ~rx0_mst_empty & ~rx0_mst_dout[17];
  assign bad1  = port_en[1] & ~rx1_mst_empty & ~rx1_mst_dout[17];

  assign xfer0 = (state == GNT0) & ~rx0_mst_empty & ~mst_full;
  assign xfer1 = (state == GNT1) & ~rx1_mst_empty & ~mst_full;
  assign end0  = xfer0 & rx0_mst_dout[16];
  assign end1  = xfer1 & rx1_mst_dout[16];

  // Discards only happen when nobody could be granted; port 0 has precedence.
  assign disc0 = (state == IDLE) & ~elig0 & ~elig1 & bad0;
  assign disc1 = (state == IDLE) & ~elig0 & ~elig1 & ~bad0 & bad1;

  always_comb begin
    pick1 = elig1;
    if (elig0 && elig1) begin
      pick1 = (FAIR != 0) ? ~last_served : 1'b0;
    end
  end

  // Strobes are forced low while reset is held so a mid-packet reset cannot pop anything.
  assign rx0_mst_rd_en = ~sys_rst & (xfer0 | disc0);
  assign rx1_mst_rd_en = ~sys_rst & (xfer1 | disc1);
  assign mst_wr_en     = ~sys_rst & (xfer0 | xfer1);
  assign proto_err     = ~sys_rst & (disc0 | disc1);
  assign mst_din       = (~sys_rst & xfer0) ? rx0_mst_dout :
                         (~sys_rst & xfer1) ? rx1_mst_dout : 18'h0;
  assign grant         = {state == GNT1, state == GNT0};

  always_ff @(posedge clk_125 or posedge sys_rst) begin
    if (sys_rst) begin
      state       <= IDLE;
      last_served <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (elig0 || elig1) begin
            state <= pick1 ? GNT1 : GNT0;
          end
        end
        GNT0: begin
          if (end0) begin
            state       <= IDLE;
            last_served <= 1'b0;
          end
        end
        GNT1: begin
          if (end1) begin
            state       <= IDLE;
            last_served <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MSTQ_ARB_STATS_EN
  logic [15:0] cnt0, cnt1;

  always_ff @(posedge clk_125 or posedge sys_rst) begin
    if (sys_rst) begin
      cnt0 <= 16'h0;
      cnt1 <= 16'h0;
    end else begin
      if (end0) cnt0 <= cnt0 + 16'd1;
      if (end1) cnt1 <= cnt1 + 16'd1;
    end
  end

  assign pkt0_cnt = cnt0;
  assign pkt1_cnt = cnt1;
`else
  assign pkt0_cnt = 16'h0;
  assign pkt1_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_mstq_arbiter.sv
// Directed self-checking bench for mstq_arbiter; expected counter values track MSTQ_ARB_STATS_EN.
module tb_mstq_arbiter;

  logic        clk_125 = 1'b0;
  logic        sys_rst;
  logic [1:0]  port_en;
  logic        rx0_mst_empty, rx1_mst_empty;
  logic [17:0] rx0_mst_dout, rx1_mst_dout;
  logic        rx0_mst_rd_en, rx1_mst_rd_en;
  logic [17:0] mst_din;
  logic        mst_wr_en;
  logic        mst_full;
  logic [1:0]  grant;
  logic        proto_err;
  logic [15:0] pkt0_cnt, pkt1_cnt;

  int compared = 0;
  int mismatched = 0;

`ifdef MSTQ_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  mstq_arbiter #(.FAIR(1)) dut (
    .clk_125(clk_125), .sys_rst(sys_rst), .port_en(port_en),
    .rx0_mst_empty(rx0_mst_empty), .rx0_mst_dout(rx0_mst_dout), .rx0_mst_rd_en(rx0_mst_rd_en),
    .rx1_mst_empty(rx1_mst_empty), .rx1_mst_dout(rx1_mst_dout), .rx1_mst_rd_en(rx1_mst_rd_en),
    .mst_din(mst_din), .mst_wr_en(mst_wr_en), .mst_full(mst_full),
    .grant(grant), .proto_err(proto_err), .pkt0_cnt(pkt0_cnt), .pkt1_cnt(pkt1_cnt)
  );

  always #5 clk_125 = ~clk_125;

  task automatic check_output(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of source heads, checks the mid-cycle outputs, then advances past the edge.
  task automatic apply_stimulus(input logic e0, input logic [17:0] d0,
                                input logic e1, input logic [17:0] d1, input logic full,
                                input logic x_rd0, input logic x_rd1, input logic x_wr,
                                input logic [17:0] x_din, input logic [1:0] x_gnt,
                                input logic x_err, input string tag);
    rx0_mst_empty = e0;
    rx0_mst_dout  = d0;
    rx1_mst_empty = e1;
    rx1_mst_dout  = d1;
    mst_full      = full;
    @(negedge clk_125);
    check_output({tag, ".rd0"},   {17'h0, rx0_mst_rd_en}, {17'h0, x_rd0});
    check_output({tag, ".rd1"},   {17'h0, rx1_mst_rd_en}, {17'h0, x_rd1});
    check_output({tag, ".wr"},    {17'h0, mst_wr_en},     {17'h0, x_wr});
    check_output({tag, ".din"},   mst_din,                x_din);
    check_output({tag, ".grant"}, {16'h0, grant},         {16'h0, x_gnt});
    check_output({tag, ".err"},   {17'h0, proto_err},     {17'h0, x_err});
    @(posedge clk_125);
    #1;
  endtask

  task automatic check_counts(input string tag, input int n0, input int n1);
    check_output({tag, ".cnt0"}, {2'b0, pkt0_cnt}, STATS ? 18'(n0) : 18'h0);
    check_output({tag, ".cnt1"}, {2'b0, pkt1_cnt}, STATS ? 18'(n1) : 18'h0);
  endtask

  initial begin
    sys_rst = 1'b1;
    port_en = 2'b11;
    apply_stimulus(1, 18'h0, 1, 18'h0, 0,  0, 0, 0, 18'h0, 2'b00, 0, "reset");
    check_counts("reset", 0, 0);
    sys_rst = 1'b0;

    // Tie out of reset: port 0 first, then port 1, no interleaving.
    apply_stimulus(0, 18'h2_0010, 0, 18'h2_0020, 0,  0, 0, 0, 18'h0,       2'b00, 0, "tie1_idle");
    apply_stimulus(0, 18'h2_0010, 0, 18'h2_0020, 0,  1, 0, 1, 18'h2_0010, 2'b01, 0, "tie1_p0w0");
    apply_stimulus(0, 18'h1_0011, 0, 18'h2_0020, 0,  1, 0, 1, 18'h1_0011, 2'b01, 0, "tie1_p0w1");
    apply_stimulus(1, 18'h0,      0, 18'h2_0020, 0,  0, 0, 0, 18'h0,       2'b00, 0, "tie1_idle2");
    apply_stimulus(1, 18'h0,      0, 18'h2_0020, 0,  0, 1, 1, 18'h2_0020, 2'b10, 0, "tie1_p1w0");
    apply_stimulus(1, 18'h0,      0, 18'h1_0021, 0,  0, 1, 1, 18'h1_0021, 2'b10, 0, "tie1_p1w1");
    check_counts("tie1", 1, 1);

    // Port 0 alone, three-word command.
    apply_stimulus(0, 18'h2_0001, 1, 18'h0, 0,  0, 0, 0, 18'h0,       2'b00, 0, "p0_idle");
    apply_stimulus(0, 18'h2_0001, 1, 18'h0, 0,  1, 0, 1, 18'h2_0001, 2'b01, 0, "p0_w0");
    apply_stimulus(0, 18'h0_0002, 1, 18'h0, 0,  1, 0, 1, 18'h0_0002, 2'b01, 0, "p0_w1");
    apply_stimulus(0, 18'h1_0003, 1, 18'h0, 0,  1, 0, 1, 18'h1_0003, 2'b01, 0, "p0_w2");
    apply_stimulus(1, 18'h0,      1, 18'h0, 0,  0, 0, 0, 18'h0,       2'b00, 0, "p0_done");
    check_counts("p0", 2, 1);

    // Port 0 was served last, so port 1 wins this tie.
    apply_stimulus(0, 18'h2_0030, 0, 18'h2_0040, 0,  0, 0, 0, 18'h0,       2'b00, 0, "tie2_idle");
    apply_stimulus(0, 18'h2_0030, 0, 18'h2_0040, 0,  0, 1, 1, 18'h2_0040, 2'b10, 0, "tie2_p1w0");
    apply_stimulus(0, 18'h2_0030, 0, 18'h1_0041, 0,  0, 1, 1, 18'h1_0041, 2'b10, 0, "tie2_p1w1");
    apply_stimulus(0, 18'h2_0030, 1, 18'h0,      0,  0, 0, 0, 18'h0,       2'b00, 0, "tie2_idle2");
    apply_stimulus(0, 18'h2_0030, 1, 18'h0,      0,  1, 0, 1, 18'h2_0030, 2'b01, 0, "tie2_p0w0");
    apply_stimulus(0, 18'h1_0031, 1, 18'h0,      0,  1, 0, 1, 18'h1_0031, 2'b01, 0, "tie2_p0w1");
    check_counts("tie2", 3, 2);

    // Full stall for five cycles and one empty bubble mid-packet.
    apply_stimulus(0, 18'h2_0050, 1, 18'h0, 0,  0, 0, 0, 18'h0,       2'b00, 0, "full_idle");
    apply_stimulus(0, 18'h2_0050, 1, 18'h0, 0,  1, 0, 1, 18'h2_0050, 2'b01, 0, "full_w0");
    for (int i = 0; i < 5; i++)
      apply_stimulus(0, 18'h0_0051, 1, 18'h0, 1,  0, 0, 0, 18'h0, 2'b01, 0, $sformatf("full_stall%0d", i));
    apply_stimulus(0, 18'h0_0051, 1, 18'h0, 0,  1, 0, 1, 18'h0_0051, 2'b01, 0, "full_w1");
    apply_stimulus(1, 18'h0,      1, 18'h0, 0,  0, 0, 0, 18'h0,       2'b01, 0, "empty_stall");
    apply_stimulus(0, 18'h1_0052, 1, 18'h0, 0,  1, 0, 1, 18'h1_0052, 2'b01, 0, "full_w2");
    check_counts("full", 4, 2);

    // Misframed heads in IDLE.
    apply_stimulus(1, 18'h0,      0, 18'h0_00AA, 0,  0, 1, 0, 18'h0,       2'b00, 1, "mis_p1");
    apply_stimulus(1, 18'h0,      1, 18'h0,      0,  0, 0, 0, 18'h0,       2'b00, 0, "mis_quiet");
    apply_stimulus(0, 18'h0_00BB, 0, 18'h0_00CC, 0,  1, 0, 0, 18'h0,       2'b00, 1, "mis_both");
    apply_stimulus(1, 18'h0,      0, 18'h0_00CC, 0,  0, 1, 0, 18'h0,       2'b00, 1, "mis_p1b");
    apply_stimulus(0, 18'h3_00C0, 0, 18'h0_00DD, 0,  0, 0, 0, 18'h0,       2'b00, 0, "mis_elig");
    apply_stimulus(0, 18'h3_00C0, 0, 18'h0_00DD, 0,  1, 0, 1, 18'h3_00C0, 2'b01, 0, "mis_single");
    apply_stimulus(1, 18'h0,      0, 18'h0_00DD, 0,  0, 1, 0, 18'h0,       2'b00, 1, "mis_after");
    check_counts("mis", 5, 2);

    // Port 1 disabled; port 0 finishes its packet after its own enable drops.
    port_en = 2'b01;
    apply_stimulus(1, 18'h0,      0, 18'h2_0060, 0,  0, 0, 0, 18'h0,       2'b00, 0, "en_block0");
    apply_stimulus(1, 18'h0,      0, 18'h0_0061, 0,  0, 0, 0, 18'h0,       2'b00, 0, "en_nodisc");
    apply_stimulus(0, 18'h2_0070, 0, 18'h2_0060, 0,  0, 0, 0, 18'h0,       2'b00, 0, "en_idle");
    apply_stimulus(0, 18'h2_0070, 0, 18'h2_0060, 0,  1, 0, 1, 18'h2_0070, 2'b01, 0, "en_w0");
    port_en = 2'b00;
    apply_stimulus(0, 18'h2_0071, 0, 18'h2_0060, 0,  1, 0, 1, 18'h2_0071, 2'b01, 0, "en_nested");
    apply_stimulus(0, 18'h1_0072, 0, 18'h2_0060, 0,  1, 0, 1, 18'h1_0072, 2'b01, 0, "en_w2");
    apply_stimulus(0, 18'h2_0073, 0, 18'h2_0060, 0,  0, 0, 0, 18'h0,       2'b00, 0, "en_off");
    check_counts("en", 6, 2);

    // Reset pulsed mid-packet; tail words are then discarded.
    port_en = 2'b11;
    apply_stimulus(0, 18'h2_0080, 1, 18'h0, 0,  0, 0, 0, 18'h0,       2'b00, 0, "rst_idle");
    apply_stimulus(0, 18'h2_0080, 1, 18'h0, 0,  1, 0, 1, 18'h2_0080, 2'b01, 0, "rst_w0");
    rx0_mst_dout = 18'h0_0081;
    #1 sys_rst = 1'b1;
    #1;
    check_output("rst_mid.grant", {16'h0, grant},         18'h0);
    check_output("rst_mid.rd0",   {17'h0, rx0_mst_rd_en}, 18'h0);
    check_output("rst_mid.wr",    {17'h0, mst_wr_en},     18'h0);
    check_output("rst_mid.err",   {17'h0, proto_err},     18'h0);
    check_output("rst_mid.din",   mst_din,                18'h0);
    @(posedge clk_125);
    #1 sys_rst = 1'b0;
    check_counts("rst_mid", 0, 0);
    apply_stimulus(0, 18'h0_0081, 1, 18'h0, 0,  1, 0, 0, 18'h0, 2'b00, 1, "rst_tail0");
    apply_stimulus(0, 18'h1_0082, 1, 18'h0, 0,  1, 0, 0, 18'h0, 2'b00, 1, "rst_tail1");

    // Last-served is back to 1 after reset: port 0 wins; single-word commands.
    apply_stimulus(0, 18'h3_0090, 0, 18'h3_00A0, 0,  0, 0, 0, 18'h0,       2'b00, 0, "sw_idle");
    apply_stimulus(0, 18'h3_0090, 0, 18'h3_00A0, 0,  1, 0, 1, 18'h3_0090, 2'b01, 0, "sw_p0");
    apply_stimulus(1, 18'h0,      0, 18'h3_00A0, 0,  0, 0, 0, 18'h0,       2'b00, 0, "sw_idle2");
    apply_stimulus(1, 18'h0,      0, 18'h3_00A0, 0,  0, 1, 1, 18'h3_00A0, 2'b10, 0, "sw_p1");
    apply_stimulus(1, 18'h0,      1, 18'h0,      0,  0, 0, 0, 18'h0,       2'b00, 0, "sw_done");
    check_counts("sw", 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
